// File: rtl/fifo_sync_ctrl_if.sv
// Handshake bundle for the single-clock FIFO. The producer/consumer side takes
// the master view and the FIFO takes the slave view.
interface fifo_sync_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;
    logic                  almost_full;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  empty;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;
    logic                  clr_err;

    modport master (
        output wr_en, wr_data, rd_en, clr_err,
        input  full, almost_full, rd_data, rd_valid, empty, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, clr_err,
        output full, almost_full, rd_data, rd_valid, empty, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO with occupancy, almost flags, standard/FWFT read mode and
// sticky overflow/underflow. Writes to a full FIFO and reads from an empty one are rejected.
module fifo_sync_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2
) (
    input logic             clk,
    input logic             rst,
    fifo_sync_ctrl_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_THRESH);

    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("fifo_sync_ctrl: AF_THRESH out of range 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("fifo_sync_ctrl: AE_THRESH out of range 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   cnt;
    logic                  ovf, unf;
    logic                  full_w, empty_w, wr_acc, rd_acc;

    assign full_w  = (cnt == DEPTH_C);
    assign empty_w = (cnt == '0);
    // No pass-through at the boundaries: full blocks the write, empty blocks the read.
    assign wr_acc  = bus.wr_en && !full_w;
    assign rd_acc  = bus.rd_en && !empty_w;

    // Storage is not reset; writes are suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc)
            mem[wr_ptr] <= bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            unique case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            // A new rejection wins over a simultaneous clear.
            if (bus.wr_en && full_w)      ovf <= 1'b1;
            else if (bus.clr_err)         ovf <= 1'b0;
            if (bus.rd_en && empty_w)     unf <= 1'b1;
            else if (bus.clr_err)         unf <= 1'b0;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign bus.rd_data  = mem[rd_ptr];
        assign bus.rd_valid = !empty_w;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] rd_data_q;
        logic                  rd_valid_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) rd_data_q <= mem[rd_ptr];
            end
        end

        assign bus.rd_data  = rd_data_q;
        assign bus.rd_valid = rd_valid_q;
    end

    assign bus.count        = cnt;
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (cnt >= AF_C);
    assign bus.almost_empty = (cnt <= AE_C);
    assign bus.overflow     = ovf;
    assign bus.underflow    = unf;
endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Directed vector bench: one standard-mode and one FWFT-mode FIFO, each driven
// from a table of per-cycle inputs and hand-derived expected outputs.
module tb_fifo_sync_ctrl;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fifo_sync_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) a_if ();
    fifo_sync_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) b_if ();

    fifo_sync_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0), .AF_THRESH(14), .AE_THRESH(2))
        u_std (.clk(clk), .rst(rst_a), .bus(a_if.slave));
    fifo_sync_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1), .AF_THRESH(14), .AE_THRESH(2))
        u_fwft (.clk(clk), .rst(rst_b), .bus(b_if.slave));

    typedef struct {
        logic       rst, wr, rd, clr;
        logic [7:0] wd;
        logic [4:0] cnt;
        logic       rv;
        logic       chk;
        logic [7:0] dat;
        logic       ovf, unf;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic w, input logic [7:0] wd, input logic rd,
                       input logic clr, input logic [4:0] cnt, input logic rv,
                       input logic chk, input logic [7:0] dat, input logic ovf, input logic unf);
        vec_t v;
        v.rst = r; v.wr = w; v.wd = wd; v.rd = rd; v.clr = clr;
        v.cnt = cnt; v.rv = rv; v.chk = chk; v.dat = dat; v.ovf = ovf; v.unf = unf;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s #%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Status word: {count, full, almost_full, empty, almost_empty, rd_valid, overflow, underflow}
    task automatic run(input bit sel, input string tag);
        logic [11:0] act, exp;
        logic [7:0]  dat;
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            if (!sel) begin
                rst_a = vq[i].rst; a_if.wr_en = vq[i].wr; a_if.wr_data = vq[i].wd;
                a_if.rd_en = vq[i].rd; a_if.clr_err = vq[i].clr;
            end else begin
                rst_b = vq[i].rst; b_if.wr_en = vq[i].wr; b_if.wr_data = vq[i].wd;
                b_if.rd_en = vq[i].rd; b_if.clr_err = vq[i].clr;
            end
            @(posedge clk);
            #1;
            if (!sel) begin
                act = {a_if.count, a_if.full, a_if.almost_full, a_if.empty, a_if.almost_empty,
                       a_if.rd_valid, a_if.overflow, a_if.underflow};
                dat = a_if.rd_data;
            end else begin
                act = {b_if.count, b_if.full, b_if.almost_full, b_if.empty, b_if.almost_empty,
                       b_if.rd_valid, b_if.overflow, b_if.underflow};
                dat = b_if.rd_data;
            end
            exp = {vq[i].cnt, vq[i].cnt == 5'd16, vq[i].cnt >= 5'd14, vq[i].cnt == 5'd0,
                   vq[i].cnt <= 5'd2, vq[i].rv, vq[i].ovf, vq[i].unf};
            check({tag, "_status"}, i, 32'(act), 32'(exp));
            if (vq[i].chk) check({tag, "_rd_data"}, i, 32'(dat), 32'(vq[i].dat));
        end
        @(negedge clk);
        if (!sel) begin
            a_if.wr_en = 1'b0; a_if.rd_en = 1'b0; a_if.clr_err = 1'b0;
        end else begin
            b_if.wr_en = 1'b0; b_if.rd_en = 1'b0; b_if.clr_err = 1'b0;
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        a_if.wr_en = 1'b0; a_if.wr_data = '0; a_if.rd_en = 1'b0; a_if.clr_err = 1'b0;
        b_if.wr_en = 1'b0; b_if.wr_data = '0; b_if.rd_en = 1'b0; b_if.clr_err = 1'b0;

        // ---- standard mode table ----
        add(1, 0, 8'h00, 0, 0, 0, 0, 1, 8'h00, 0, 0);               // reset values
        for (int i = 1; i <= 16; i++)                                 // fill 0x01..0x10
            add(0, 1, 8'(i), 0, 0, 5'(i), 0, 0, 8'h00, 0, 0);
        add(0, 1, 8'hFF, 1, 0, 15, 1, 1, 8'h01, 1, 0);               // full: read only, 0xFF dropped
        add(0, 0, 8'h00, 0, 1, 15, 0, 1, 8'h01, 0, 0);               // clr_err, rd_data holds
        for (int j = 2; j <= 16; j++)                                 // drain 0x02..0x10
            add(0, 0, 8'h00, 1, 0, 5'(16 - j), 1, 1, 8'(j), 0, 0);
        add(0, 0, 8'h00, 1, 0, 0, 0, 1, 8'h10, 0, 1);                // read while empty
        add(0, 0, 8'h00, 0, 1, 0, 0, 1, 8'h10, 0, 0);                // clear underflow
        add(0, 1, 8'h3C, 1, 0, 1, 0, 1, 8'h10, 0, 1);                // empty: write only
        add(0, 0, 8'h00, 1, 0, 0, 1, 1, 8'h3C, 0, 1);                // read returns 0x3C
        add(0, 1, 8'hEE, 0, 1, 1, 0, 0, 8'h00, 0, 0);                // set-free clear + write
        add(0, 0, 8'h00, 1, 0, 0, 1, 1, 8'hEE, 0, 0);
        for (int i = 0; i < 10; i++)
            add(0, 1, 8'(8'h40 + i), 0, 0, 5'(i + 1), 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 10; i++)
            add(0, 0, 8'h00, 1, 0, 5'(9 - i), 1, 1, 8'(8'h40 + i), 0, 0);
        for (int i = 0; i < 12; i++)                                  // wraps write pointer
            add(0, 1, 8'(8'h50 + i), 0, 0, 5'(i + 1), 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 6; i++)                                   // reads cross the wrap
            add(0, 0, 8'h00, 1, 0, 5'(11 - i), 1, 1, 8'(8'h50 + i), 0, 0);
        for (int i = 0; i < 3; i++)                                   // simultaneous r/w, count flat
            add(0, 1, 8'(8'h60 + i), 1, 0, 6, 1, 1, 8'(8'h56 + i), 0, 0);
        add(1, 1, 8'h99, 1, 0, 0, 0, 1, 8'h00, 0, 0);                // reset mid-stream
        add(0, 0, 8'h00, 1, 0, 0, 0, 1, 8'h00, 0, 1);                // read after reset rejected
        run(1'b0, "std");

        // ---- FWFT table ----
        vq.delete();
        add(1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        add(0, 1, 8'hA5, 0, 0, 1, 1, 1, 8'hA5, 0, 0);                // falls through next cycle
        add(0, 1, 8'h5A, 0, 0, 2, 1, 1, 8'hA5, 0, 0);
        add(0, 0, 8'h00, 1, 0, 1, 1, 1, 8'h5A, 0, 0);                // pop presents next word
        add(0, 1, 8'h77, 1, 0, 1, 1, 1, 8'h77, 0, 0);
        add(0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0);                // back to empty
        add(0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 1);                // pop while empty
        for (int i = 1; i <= 16; i++)
            add(0, 1, 8'(8'h80 + i), 0, 0, 5'(i), 1, 1, 8'h81, 0, 1);
        add(0, 1, 8'hFF, 0, 1, 16, 1, 1, 8'h81, 1, 0);               // overflow beats clr_err
        run(1'b1, "fwft");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
